dclock_set_ctrl: RTL

- Controller that sequences the loadable HH:MM:SS timekeeper counter.
- Generates the 1 Hz count-enable pulse from the system clock.
- Runs a button-driven time-setting state machine that freezes counting, edits hours, minutes and seconds in turn, then loads the new time into the timekeeper.
- Sits between the board button inputs, already synchronised and debounced upstream, and the timekeeper datapath.

---
 rtl/dclock_pkg.sv | 35 +++
 rtl/dclock_set_ctrl_if.sv | 29 ++
 rtl/dclock_prescaler.sv | 32 +++
 rtl/dclock_set_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dclock_pkg.sv
// Shared types and constants for the HH:MM:SS set controller and its prescaler.
// Pure declarations and helpers; no state, no latency.
package dclock_pkg;

    localparam int TF_W = 7;

    typedef logic [TF_W-1:0] tf_t;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_H = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_S = 2'd3
    } mode_e;

    localparam tf_t HRS_MAX = 7'd23;
    localparam tf_t MIN_MAX = 7'd59;
    localparam tf_t SEC_MAX = 7'd59;

    typedef struct packed {
        tf_t hrs;
        tf_t mins;
        tf_t secs;
    } hms_t;

    // Terminal compare rather than overflow, so each field wraps at its own limit.
    function automatic tf_t tf_wrap_inc(input tf_t v, input tf_t lim);
        return (v == lim) ? '0 : v + 7'd1;
    endfunction

    function automatic tf_t tf_sanitise(input tf_t v, input tf_t lim);
        return (v > lim) ? '0 : v;
    endfunction

endpackage

// File: rtl/dclock_set_ctrl_if.sv
// Button, timekeeper-readback and load/tick signals between board, controller and timekeeper.
// Plain wires; the controller side registers every output it drives.
interface dclock_set_ctrl_if;
    import dclock_pkg::*;

    logic        btn_mode;
    logic        btn_inc;
    tf_t         cur_hrs;
    tf_t         cur_min;
    tf_t         cur_sec;
    logic        tick_en;
    logic        load;
    tf_t         ld_hrs;
    tf_t         ld_min;
    tf_t         ld_sec;
    logic [1:0]  mode;
    logic        blink;

    modport master (
        input  btn_mode, btn_inc, cur_hrs, cur_min, cur_sec,
        output tick_en, load, ld_hrs, ld_min, ld_sec, mode, blink
    );

    modport slave (
        output btn_mode, btn_inc, cur_hrs, cur_min, cur_sec,
        input  tick_en, load, ld_hrs, ld_min, ld_sec, mode, blink
    );

endinterface

// File: rtl/dclock_prescaler.sv
// Free-running CLK_HZ counter with synchronous clear and terminal / half-terminal strobes.
// Strobes are combinational from the count register; no backpressure.
module dclock_prescaler #(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = $clog2(CLK_HZ)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_term,
    output logic o_half
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_HZ / 2 - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_term = (r_cnt == TERM);
    assign o_half = (r_cnt == HALF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dclock_set_ctrl.sv
// Time-set FSM for the HH:MM:SS timekeeper: 1 Hz tick, button edit of h/m/s, one-cycle load.
// All outputs registered (one cycle after the causing edge); buttons are levels, only rising edges act.
module dclock_set_ctrl
    import dclock_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = $clog2(CLK_HZ)
) (
    input  logic             clk,
    input  logic             rst,
    dclock_set_ctrl_if.master bus
);

    mode_e r_state;
    mode_e w_state_nxt;

    logic  r_mode_q;
    logic  r_inc_q;
    logic  w_mode_edge;
    logic  w_inc_edge;

    hms_t  r_edit;
    hms_t  r_ld;
    logic  r_load;
    logic  r_tick;
    logic  r_blink;

    logic  w_capture;
    logic  w_do_load;
    logic  w_inc_h;
    logic  w_inc_m;
    logic  w_inc_s;
    logic  w_term;
    logic  w_half;

    assign w_mode_edge = bus.btn_mode & ~r_mode_q;
    assign w_inc_edge  = bus.btn_inc  & ~r_inc_q;

    dclock_prescaler #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_do_load),
        .o_term (w_term),
        .o_half (w_half)
    );

    // History resets high so a button held through reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= 1'b1;
            r_inc_q  <= 1'b1;
        end else begin
            r_mode_q <= bus.btn_mode;
            r_inc_q  <= bus.btn_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MODE_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode edge is checked first in every SET state, so a coincident increment is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_do_load   = 1'b0;
        w_inc_h     = 1'b0;
        w_inc_m     = 1'b0;
        w_inc_s     = 1'b0;
        case (r_state)
            MODE_RUN: begin
                if (w_mode_edge) begin
                    w_state_nxt = MODE_SET_H;
                    w_capture   = 1'b1;
                end
            end
            MODE_SET_H: begin
                if (w_mode_edge)     w_state_nxt = MODE_SET_M;
                else if (w_inc_edge) w_inc_h     = 1'b1;
            end
            MODE_SET_M: begin
                if (w_mode_edge)     w_state_nxt = MODE_SET_S;
                else if (w_inc_edge) w_inc_m     = 1'b1;
            end
            MODE_SET_S: begin
                if (w_mode_edge) begin
                    w_state_nxt = MODE_RUN;
                    w_do_load   = 1'b1;
                end else if (w_inc_edge) begin
                    w_inc_s = 1'b1;
                end
            end
            default: w_state_nxt = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edit <= '0;
        end else if (w_capture) begin
            r_edit.hrs  <= tf_sanitise(bus.cur_hrs, HRS_MAX);
            r_edit.mins <= tf_sanitise(bus.cur_min, MIN_MAX);
            r_edit.secs <= tf_sanitise(bus.cur_sec, SEC_MAX);
        end else begin
            if (w_inc_h) r_edit.hrs  <= tf_wrap_inc(r_edit.hrs,  HRS_MAX);
            if (w_inc_m) r_edit.mins <= tf_wrap_inc(r_edit.mins, MIN_MAX);
            if (w_inc_s) r_edit.secs <= tf_wrap_inc(r_edit.secs, SEC_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load  <= 1'b0;
            r_ld    <= '0;
            r_tick  <= 1'b0;
            r_blink <= 1'b0;
        end else begin
            r_load <= w_do_load;
            if (w_do_load) r_ld <= r_edit;
            // Only RUN ticks; the exit cycle is still SET_S, so load and tick never coincide.
            r_tick <= w_term && (r_state == MODE_RUN);
            if (r_state == MODE_RUN || w_state_nxt == MODE_RUN) begin
                r_blink <= 1'b0;
            end else if (w_half || w_term) begin
                r_blink <= ~r_blink;
            end
        end
    end

    assign bus.tick_en = r_tick;
    assign bus.load    = r_load;
    assign bus.ld_hrs  = r_ld.hrs;
    assign bus.ld_min  = r_ld.mins;
    assign bus.ld_sec  = r_ld.secs;
    assign bus.mode    = r_state;
    assign bus.blink   = r_blink;

endmodule
